// File: rtl/row_memory_scheduler_if.sv
// Shared generation-memory port used by the row scheduler.
// master = scheduler side, slave = arbiter/memory side.
interface row_memory_scheduler_if #(
  parameter int ADDR_W = 16
);
  logic              memReq;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [15:0]       memWData;
  logic              memGnt;
  logic [15:0]       memRData;

  modport master (
    output memReq, memWe, memAddr, memWData,
    input  memGnt, memRData
  );

  modport slave (
    input  memReq, memWe, memAddr, memWData,
    output memGnt, memRData
  );
endinterface

// File: rtl/row_memory_scheduler.sv
// Per-scanline sequencer: writes the finished row back, then fetches the next source row
// from the ping-pong generation memory and presents it as one 640-bit register.
module row_memory_scheduler #(
  parameter int WORDS  = 40,
  parameter int ROWS   = 480,
  parameter int ADDR_W = 16
) (
  input  logic                  clkDiv,
  input  logic                  rst,
  input  logic                  lineStart,
  input  logic [8:0]            row,
  input  logic                  run,
  input  logic [WORDS*16-1:0]   writeRow,
  row_memory_scheduler_if.master mem,
  output logic [WORDS*16-1:0]   readRow,
  output logic                  reading,
  output logic                  bank,
  output logic                  overrun
);
  localparam int K_W        = $clog2(WORDS);
  localparam int BANK_WORDS = ROWS * WORDS;

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, PRESENT} state_t;

  state_t              state_reg;
  logic [K_W-1:0]      k_reg;
  logic [ADDR_W-1:0]   wr_base_reg;
  logic [ADDR_W-1:0]   rd_base_reg;
  logic                rd_valid_reg;
  logic [K_W-1:0]      rd_k_reg;
  logic                present_reg;
  logic [WORDS*16-1:0] staging_reg;

  logic [WORDS*16-1:0] staging_next;
  logic [15:0]         write_words [WORDS];
  logic [8:0]          wr_idx;
  logic [8:0]          rd_idx;
  logic [ADDR_W-1:0]   wr_calc;
  logic [ADDR_W-1:0]   rd_calc;
  logic                busy;
  logic                accept;
  logic                last_k;

  assign busy   = (state_reg == WRITE) || (state_reg == READ);
  assign accept = busy && mem.memGnt;
  assign last_k = (k_reg == K_W'(WORDS - 1));

  // Toroidal row neighbours; only meaningful when row < ROWS.
  assign wr_idx  = (row == 9'd0) ? 9'(ROWS - 1) : row - 9'd1;
  assign rd_idx  = (row >= 9'(ROWS - 2)) ? row - 9'(ROWS - 2) : row + 9'd2;
  assign wr_calc = (bank ? ADDR_W'(0) : ADDR_W'(BANK_WORDS)) + ADDR_W'(wr_idx) * ADDR_W'(WORDS);
  assign rd_calc = (bank ? ADDR_W'(BANK_WORDS) : ADDR_W'(0)) + ADDR_W'(rd_idx) * ADDR_W'(WORDS);

  assign mem.memReq   = busy;
  assign mem.memWe    = (state_reg == WRITE);
  assign mem.memAddr  = busy ? ((state_reg == WRITE) ? wr_base_reg : rd_base_reg) + ADDR_W'(k_reg)
                             : '0;
  assign mem.memWData = (state_reg == WRITE) ? write_words[k_reg] : 16'd0;

  // Read data lands one cycle after its accept, so it is steered by the registered
  // word index rather than anything in the current cycle.
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
    assign write_words[gi] = writeRow[gi*16 +: 16];
    assign staging_next[gi*16 +: 16] = (rd_valid_reg && rd_k_reg == K_W'(gi))
                                       ? mem.memRData : staging_reg[gi*16 +: 16];
  end

  always_ff @(posedge clkDiv or negedge rst) begin
    if (!rst) staging_reg <= '0;
    else      staging_reg <= staging_next;
  end

  always_ff @(posedge clkDiv or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      k_reg        <= '0;
      wr_base_reg  <= '0;
      rd_base_reg  <= '0;
      rd_valid_reg <= 1'b0;
      rd_k_reg     <= '0;
      present_reg  <= 1'b0;
      readRow      <= '0;
      reading      <= 1'b0;
      bank         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      rd_valid_reg <= accept && (state_reg == READ);
      if (accept && (state_reg == READ)) rd_k_reg <= k_reg;
      if (lineStart && (state_reg != IDLE)) overrun <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (lineStart) begin
            if (row < 9'(ROWS)) begin
              wr_base_reg <= wr_calc;
              rd_base_reg <= rd_calc;
              k_reg       <= '0;
              state_reg   <= run ? WRITE : READ;
            end else if (row == 9'(ROWS) && run) begin
              bank <= ~bank;
            end
          end
        end
        WRITE: begin
          if (accept) begin
            if (last_k) begin
              k_reg     <= '0;
              state_reg <= READ;
            end else begin
              k_reg <= k_reg + K_W'(1);
            end
          end
        end
        READ: begin
          if (accept) begin
            if (last_k) begin
              k_reg     <= '0;
              state_reg <= DRAIN;
            end else begin
              k_reg <= k_reg + K_W'(1);
            end
          end
        end
        DRAIN: begin
          // staging_next already carries the final word arriving this cycle.
          readRow     <= staging_next;
          reading     <= 1'b1;
          present_reg <= 1'b0;
          state_reg   <= PRESENT;
        end
        PRESENT: begin
          if (present_reg) begin
            reading   <= 1'b0;
            state_reg <= IDLE;
          end else begin
            present_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule
